// File: rtl/audio_source_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_source_arbiter_if
// Brief    : Request/response bundle between the audio requesters and arbiter.
// Revision : 1.0
// ============================================================================
interface audio_source_arbiter_if #(
  parameter int PL_W = 20
);
  logic            alarm_req;
  logic            time_req;
  logic [PL_W-1:0] time_playlist;
  logic            hour_req;
  logic [PL_W-1:0] hour_playlist;
  logic            voice_done;
  logic            alarm_en;
  logic            aud_en;
  logic [PL_W-1:0] playlist_no;
  logic [1:0]      src;
  logic            busy;
  logic            timeout_err;

  modport master (
    output alarm_req, time_req, time_playlist, hour_req, hour_playlist, voice_done,
    input  alarm_en, aud_en, playlist_no, src, busy, timeout_err
  );

  modport slave (
    input  alarm_req, time_req, time_playlist, hour_req, hour_playlist, voice_done,
    output alarm_en, aud_en, playlist_no, src, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/audio_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_source_arbiter
// Brief    : Shared audio PWM path arbiter (alarm / time / hour) with guard gap
//            and voice watchdog. Option macro: AUD_ARB_PREEMPT_EN (alarm
//            preempts voice playback).
// Revision : 1.0
// ============================================================================
module audio_source_arbiter #(
  parameter int PL_W          = 20,
  parameter int GAP_CYCLES    = 1000,
  parameter int VOICE_TIMEOUT = 500000000,
  parameter int TO_W          = 29
) (
  input  wire logic            clk,
  input  wire logic            sysreset,
  audio_source_arbiter_if.slave bus
);

  localparam int                c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]    c_WD_LAST  = TO_W'(VOICE_TIMEOUT - 1);

  localparam logic [1:0] c_SRC_NONE  = 2'd0;
  localparam logic [1:0] c_SRC_ALARM = 2'd1;
  localparam logic [1:0] c_SRC_TIME  = 2'd2;
  localparam logic [1:0] c_SRC_HOUR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_ALARM = 2'd2,
    S_VOICE = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_tgt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [TO_W-1:0]    r_wd_cnt;
  logic               r_time_pend;
  logic               r_hour_pend;
  logic [PL_W-1:0]    r_time_pl;
  logic [PL_W-1:0]    r_hour_pl;
  logic               r_alarm_en;
  logic               r_aud_en;
  logic [PL_W-1:0]    r_playlist_no;
  logic [1:0]         r_src;
  logic               r_busy;
  logic               r_timeout_err;
  logic [1:0]         w_pick;

  assign w_pick = bus.alarm_req ? c_SRC_ALARM :
                  r_time_pend   ? c_SRC_TIME  :
                  r_hour_pend   ? c_SRC_HOUR  : c_SRC_NONE;

  always_ff @(posedge clk or negedge sysreset) begin
    if (!sysreset) begin
      r_state       <= S_IDLE;
      r_tgt         <= c_SRC_NONE;
      r_gap_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_time_pend   <= 1'b0;
      r_hour_pend   <= 1'b0;
      r_time_pl     <= '0;
      r_hour_pl     <= '0;
      r_alarm_en    <= 1'b0;
      r_aud_en      <= 1'b0;
      r_playlist_no <= '0;
      r_src         <= c_SRC_NONE;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick != c_SRC_NONE) begin
            r_state   <= S_GAP;
            r_tgt     <= w_pick;
            r_gap_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            // Target re-evaluated here so a request raised during the gap can win.
            r_tgt <= w_pick;
            case (w_pick)
              c_SRC_ALARM: begin
                r_state    <= S_ALARM;
                r_alarm_en <= 1'b1;
                r_src      <= c_SRC_ALARM;
              end
              c_SRC_TIME: begin
                r_state       <= S_VOICE;
                r_aud_en      <= 1'b1;
                r_src         <= c_SRC_TIME;
                r_playlist_no <= r_time_pl;
                r_time_pend   <= 1'b0;
                r_wd_cnt      <= '0;
              end
              c_SRC_HOUR: begin
                r_state       <= S_VOICE;
                r_aud_en      <= 1'b1;
                r_src         <= c_SRC_HOUR;
                r_playlist_no <= r_hour_pl;
                r_hour_pend   <= 1'b0;
                r_wd_cnt      <= '0;
              end
              default: begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            endcase
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          end
        end
        S_ALARM: begin
          if (!bus.alarm_req) begin
            r_state    <= S_IDLE;
            r_alarm_en <= 1'b0;
            r_src      <= c_SRC_NONE;
            r_busy     <= 1'b0;
          end
        end
        S_VOICE: begin
          if (bus.voice_done || (r_wd_cnt == c_WD_LAST)) begin
            r_state       <= S_IDLE;
            r_aud_en      <= 1'b0;
            r_src         <= c_SRC_NONE;
            r_busy        <= 1'b0;
            r_timeout_err <= !bus.voice_done;
          end else begin
`ifdef AUD_ARB_PREEMPT_EN
            if (bus.alarm_req) begin
              // Re-arm the interrupted announcement so it replays after the alarm.
              r_state   <= S_GAP;
              r_tgt     <= c_SRC_ALARM;
              r_gap_cnt <= '0;
              r_aud_en  <= 1'b0;
              r_src     <= c_SRC_NONE;
              if (r_tgt == c_SRC_TIME) r_time_pend <= 1'b1;
              else                     r_hour_pend <= 1'b1;
            end else
`endif
              r_wd_cnt <= r_wd_cnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // New requests override the grant-time clear so nothing is lost.
      if (bus.time_req) begin
        r_time_pend <= 1'b1;
        r_time_pl   <= bus.time_playlist;
      end
      if (bus.hour_req) begin
        r_hour_pend <= 1'b1;
        r_hour_pl   <= bus.hour_playlist;
      end
    end
  end

  assign bus.alarm_en    = r_alarm_en;
  assign bus.aud_en      = r_aud_en;
  assign bus.playlist_no = r_playlist_no;
  assign bus.src         = r_src;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_audio_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_source_arbiter
// Brief    : Directed bench for audio_source_arbiter (GAP=4, TIMEOUT=50).
// Revision : 1.0
// ============================================================================
module tb_audio_source_arbiter;

  localparam int PL_W = 20;

  logic clk;
  logic sysreset;
  int   n_pass;
  int   n_total;

  audio_source_arbiter_if #(.PL_W(PL_W)) bus ();

  audio_source_arbiter #(
    .PL_W(PL_W), .GAP_CYCLES(4), .VOICE_TIMEOUT(50), .TO_W(29)
  ) u_dut (
    .clk(clk), .sysreset(sysreset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_time(input logic [PL_W-1:0] pl);
    bus.time_playlist = pl;
    bus.time_req      = 1'b1;
    tick();
    bus.time_req      = 1'b0;
  endtask

  task automatic pulse_done();
    bus.voice_done = 1'b1;
    tick();
    bus.voice_done = 1'b0;
  endtask

  // Called one edge after the request was captured; expects VOICE 5 edges later.
  task automatic expect_voice(input string tag, input logic [PL_W-1:0] pl, input logic [1:0] s);
    tick();
    check({tag, "_gap_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_gap_src"}, {30'd0, bus.src}, 32'd0);
    repeat (3) tick();
    check({tag, "_gap_aud"}, {31'd0, bus.aud_en}, 32'd0);
    tick();
    check({tag, "_aud"}, {31'd0, bus.aud_en}, 32'd1);
    check({tag, "_pl"}, {12'd0, bus.playlist_no}, {12'd0, pl});
    check({tag, "_src"}, {30'd0, bus.src}, {30'd0, s});
  endtask

  always @(negedge clk) begin
    if (sysreset) begin
      check("excl", {31'd0, bus.alarm_en & bus.aud_en}, 32'd0);
      check("src_quiet", (!bus.alarm_en && !bus.aud_en) ? {30'd0, bus.src} : 32'd0, 32'd0);
    end
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.alarm_req = 1'b0; bus.time_req = 1'b0; bus.hour_req = 1'b0; bus.voice_done = 1'b0;
    bus.time_playlist = '0; bus.hour_playlist = '0;
    sysreset = 1'b1;
    #1 sysreset = 1'b0;
    tick(); tick();
    check("rst_alarm", {31'd0, bus.alarm_en}, 32'd0);
    check("rst_aud", {31'd0, bus.aud_en}, 32'd0);
    check("rst_pl", {12'd0, bus.playlist_no}, 32'd0);
    check("rst_src", {30'd0, bus.src}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_err", {31'd0, bus.timeout_err}, 32'd0);
    sysreset = 1'b1;
    tick();

    // 1: single time announcement
    pulse_time(20'h00123);
    check("t1_pend_idle", {31'd0, bus.busy}, 32'd0);
    expect_voice("t1", 20'h00123, 2'd2);
    repeat (9) tick();
    check("t1_still", {31'd0, bus.aud_en}, 32'd1);
    pulse_done();
    check("t1_end_aud", {31'd0, bus.aud_en}, 32'd0);
    check("t1_end_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_end_src", {30'd0, bus.src}, 32'd0);
    tick();

    // 2: simultaneous time + hour
    bus.time_playlist = 20'h00011; bus.hour_playlist = 20'h00022;
    bus.time_req = 1'b1; bus.hour_req = 1'b1;
    tick();
    bus.time_req = 1'b0; bus.hour_req = 1'b0;
    expect_voice("t2a", 20'h00011, 2'd2);
    repeat (3) tick();
    pulse_done();
    check("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
    expect_voice("t2b", 20'h00022, 2'd3);
    pulse_done();
    repeat (3) tick();
    check("t2_final_busy", {31'd0, bus.busy}, 32'd0);

    // 3: watchdog timeout
    pulse_time(20'h00333);
    expect_voice("t3", 20'h00333, 2'd2);
    repeat (49) tick();
    check("t3_pre_aud", {31'd0, bus.aud_en}, 32'd1);
    check("t3_pre_err", {31'd0, bus.timeout_err}, 32'd0);
    tick();
    check("t3_err", {31'd0, bus.timeout_err}, 32'd1);
    check("t3_aud", {31'd0, bus.aud_en}, 32'd0);
    check("t3_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("t3_err_pulse", {31'd0, bus.timeout_err}, 32'd0);

    // 4: alarm raised ten cycles into playback
    pulse_time(20'h00044);
    expect_voice("t4", 20'h00044, 2'd2);
    repeat (9) tick();
    bus.alarm_req = 1'b1;
    tick();
`ifdef AUD_ARB_PREEMPT_EN
    check("t4p_aud_drop", {31'd0, bus.aud_en}, 32'd0);
    check("t4p_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) tick();
    check("t4p_gap_alarm", {31'd0, bus.alarm_en}, 32'd0);
    tick();
    check("t4p_alarm", {31'd0, bus.alarm_en}, 32'd1);
    check("t4p_src", {30'd0, bus.src}, 32'd1);
    repeat (5) tick();
    bus.alarm_req = 1'b0;
    tick();
    check("t4p_alarm_off", {31'd0, bus.alarm_en}, 32'd0);
    check("t4p_idle", {31'd0, bus.busy}, 32'd0);
    expect_voice("t4p_replay", 20'h00044, 2'd2);
    pulse_done();
`else
    check("t4n_aud_keep", {31'd0, bus.aud_en}, 32'd1);
    repeat (5) tick();
    check("t4n_no_alarm", {31'd0, bus.alarm_en}, 32'd0);
    pulse_done();
    check("t4n_aud_off", {31'd0, bus.aud_en}, 32'd0);
    tick();
    check("t4n_gap_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) tick();
    check("t4n_gap_alarm", {31'd0, bus.alarm_en}, 32'd0);
    tick();
    check("t4n_alarm", {31'd0, bus.alarm_en}, 32'd1);
    check("t4n_src", {30'd0, bus.src}, 32'd1);
    bus.alarm_req = 1'b0;
    tick();
    check("t4n_alarm_off", {31'd0, bus.alarm_en}, 32'd0);
`endif
    repeat (3) tick();
    check("t4_final_busy", {31'd0, bus.busy}, 32'd0);

    // 5: reset during playback with an hour request pending
    pulse_time(20'h00055);
    expect_voice("t5", 20'h00055, 2'd2);
    repeat (3) tick();
    bus.hour_playlist = 20'h00066;
    bus.hour_req = 1'b1;
    tick();
    bus.hour_req = 1'b0;
    #2 sysreset = 1'b0;
    #1;
    check("t5_aud", {31'd0, bus.aud_en}, 32'd0);
    check("t5_pl", {12'd0, bus.playlist_no}, 32'd0);
    check("t5_src", {30'd0, bus.src}, 32'd0);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    tick(); tick();
    sysreset = 1'b1;
    tick();
    pulse_done();
    repeat (8) tick();
    check("t5_no_replay", {31'd0, bus.busy}, 32'd0);
    check("t5_no_aud", {31'd0, bus.aud_en}, 32'd0);
    check("t5_no_err", {31'd0, bus.timeout_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
